// File: rtl/rv32i_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_fetch_stage
// Purpose  : RV32I instruction fetch with one outstanding request, redirect
//            kill, stall buffering and NOP bubble insertion into decode.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        stall_i,
    input  logic        fetch_nop_i,
    input  logic [2:0]  pc_next_sel_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] jal_target_i,
    input  logic [31:0] jalr_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_dec_o,
    output logic        valid_dec_o
);

    typedef enum logic [0:0] {
        ST_ISSUE = 1'b0,
        ST_WAIT  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_dec_q, pc_dec_d;
    logic        valid_dec_q, valid_dec_d;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_req;
    logic        w_accept;
    logic        w_resp;
    logic        w_resp_live;
    logic        w_avail;
    logic [31:0] w_avail_data;
    logic        w_consume;

    always_comb begin
        w_redirect = 1'b0;
        w_target   = pc_q;
        case (pc_next_sel_i)
            3'd1: begin w_redirect = 1'b1; w_target = branch_target_i; end
            3'd2: begin w_redirect = 1'b1; w_target = jal_target_i;    end
            3'd3: begin w_redirect = 1'b1; w_target = jalr_target_i;   end
            default: begin w_redirect = 1'b0; w_target = pc_q; end
        endcase

        // A buffered word must be consumed before pc_q advances, so no new
        // request may go out while the buffer is occupied.
        w_req        = (state_q == ST_ISSUE) && !stall_i && !buf_valid_q && !reset_i;
        w_accept     = w_req && imem_gnt_i;
        w_resp       = (state_q == ST_WAIT) && imem_rvalid_i;
        w_resp_live  = w_resp && !kill_q;
        w_avail      = w_resp_live || buf_valid_q;
        w_avail_data = buf_valid_q ? buf_data_q : imem_rdata_i;
        w_consume    = !w_redirect && !stall_i && w_avail;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        instr_d     = instr_q;
        pc_dec_d    = pc_dec_q;
        valid_dec_d = valid_dec_q;

        case (state_q)
            ST_ISSUE: if (w_accept) state_d = ST_WAIT;
            ST_WAIT:  if (imem_rvalid_i) state_d = ST_ISSUE;
            default:  state_d = ST_ISSUE;
        endcase

        // A redirect orphans any request still in flight, including one
        // granted on this very edge at the old PC.
        if (w_redirect) begin
            kill_d = ((state_q == ST_WAIT) && !imem_rvalid_i) || w_accept;
        end else if (w_resp) begin
            kill_d = 1'b0;
        end

        if (w_redirect) begin
            pc_d = w_target;
        end else if (w_consume) begin
            pc_d = pc_q + 32'd4;
        end

        if (w_redirect) begin
            buf_valid_d = 1'b0;
        end else if (stall_i && w_resp_live) begin
            buf_valid_d = 1'b1;
            buf_data_d  = imem_rdata_i;
        end else if (!stall_i) begin
            buf_valid_d = 1'b0;
        end

        if (w_redirect) begin
            instr_d     = NOP_INSTR;
            valid_dec_d = 1'b0;
        end else if (stall_i) begin
            instr_d     = instr_q;
            valid_dec_d = valid_dec_q;
        end else if (w_consume) begin
            pc_dec_d = pc_q;
            if (fetch_nop_i) begin
                instr_d     = NOP_INSTR;
                valid_dec_d = 1'b0;
            end else begin
                instr_d     = w_avail_data;
                valid_dec_d = 1'b1;
            end
        end else begin
            instr_d     = NOP_INSTR;
            valid_dec_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_ISSUE;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= NOP_INSTR;
            instr_q     <= NOP_INSTR;
            pc_dec_q    <= RESET_PC;
            valid_dec_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            instr_q     <= instr_d;
            pc_dec_q    <= pc_dec_d;
            valid_dec_q <= valid_dec_d;
        end
    end

    assign imem_req_o    = w_req;
    assign imem_addr_o   = pc_q;
    assign instruction_o = instr_q;
    assign pc_dec_o      = pc_dec_q;
    assign valid_dec_o   = valid_dec_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_fetch_stage
// Purpose  : Scoreboard bench for rv32i_fetch_stage with memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_fetch_stage;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        fetch_nop_i = 1'b0;
    logic [2:0]  pc_next_sel_i = 3'd0;
    logic [31:0] branch_target_i = '0;
    logic [31:0] jal_target_i = '0;
    logic [31:0] jalr_target_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] instruction_o;
    logic [31:0] pc_dec_o;
    logic        valid_dec_o;

    rv32i_fetch_stage #(.RESET_PC(C_RESET_PC), .NOP_INSTR(C_NOP)) dut (
        .clk_i(clk), .reset_i(reset_i), .stall_i(stall_i), .fetch_nop_i(fetch_nop_i),
        .pc_next_sel_i(pc_next_sel_i), .branch_target_i(branch_target_i),
        .jal_target_i(jal_target_i), .jalr_target_i(jalr_target_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instruction_o(instruction_o), .pc_dec_o(pc_dec_o), .valid_dec_o(valid_dec_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Architectural view: next fetch PC, the one in-flight request, and a
    // returned word waiting to enter decode.
    logic [31:0] m_pc = C_RESET_PC;
    logic        m_out = 1'b0;
    logic [31:0] m_out_addr = '0;
    logic        m_kill = 1'b0;
    logic        m_pend = 1'b0;
    logic [31:0] m_pend_addr = '0;
    logic [63:0] expq[$];
    logic [31:0] grants[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A7;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic st, input logic [2:0] sel, input logic [31:0] tgt,
                         input logic fn, input logic g, input logic rv, input logic rs);
        logic        exp_req, redir, resp, acc;
        logic [31:0] t, pc_old;
        @(negedge clk);
        stall_i         = st;
        pc_next_sel_i   = sel;
        branch_target_i = tgt;
        jal_target_i    = tgt + 32'h40;
        jalr_target_i   = tgt + 32'h80;
        fetch_nop_i     = fn;
        imem_gnt_i      = g;
        imem_rvalid_i   = rv;
        imem_rdata_i    = mem_word(m_out_addr);
        reset_i         = rs;
        #1;
        exp_req = !rs && !st && !m_out && !m_pend;
        check("imem_req", {31'd0, imem_req_o}, {31'd0, exp_req});
        if (!rs) check("imem_addr", imem_addr_o, m_pc);
        acc = exp_req && g;
        if (acc) grants.push_back(m_pc);
        @(posedge clk);
        pc_old = m_pc;
        if (rs) begin
            m_pc = C_RESET_PC; m_out = 1'b0; m_kill = 1'b0; m_pend = 1'b0;
        end else begin
            redir = (sel >= 3'd1) && (sel <= 3'd3);
            t = (sel == 3'd1) ? tgt : (sel == 3'd2) ? tgt + 32'h40 : tgt + 32'h80;
            resp = rv && m_out;
            if (redir) begin
                m_pend = 1'b0;
                if (m_out && !resp) m_kill = 1'b1;
                m_pc = t;
            end else begin
                if (resp && !m_kill) begin
                    m_pend = 1'b1;
                    m_pend_addr = m_out_addr;
                end
                if (m_pend && !st) begin
                    if (!fn) expq.push_back({m_pend_addr, mem_word(m_pend_addr)});
                    m_pc = m_pc + 32'd4;
                    m_pend = 1'b0;
                end
            end
            if (resp) begin m_out = 1'b0; m_kill = 1'b0; end
            if (acc) begin m_out = 1'b1; m_out_addr = pc_old; m_kill = redir; end
        end
    endtask

    // Monitor: every fresh valid decode entry must match the scoreboard head.
    initial begin
        logic        st_edge, rs_edge;
        logic [31:0] last_i, last_pc;
        logic [63:0] e;
        last_i = C_NOP; last_pc = C_RESET_PC;
        forever begin
            @(posedge clk);
            st_edge = stall_i;
            rs_edge = reset_i;
            @(negedge clk);
            if (rs_edge) begin
                check("rst_valid", {31'd0, valid_dec_o}, 32'd0);
                check("rst_instr", instruction_o, C_NOP);
                check("rst_pc_dec", pc_dec_o, C_RESET_PC);
            end else if (valid_dec_o) begin
                if (st_edge) begin
                    check("hold_instr", instruction_o, last_i);
                    check("hold_pc", pc_dec_o, last_pc);
                end else if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid actual=%08h@%08h expected=none", instruction_o, pc_dec_o);
                end else begin
                    e = expq.pop_front();
                    check("dec_instr", instruction_o, e[31:0]);
                    check("dec_pc", pc_dec_o, e[63:32]);
                end
            end else begin
                check("bubble_instr", instruction_o, C_NOP);
            end
            last_i = instruction_o;
            last_pc = pc_dec_o;
        end
    end

    initial begin
        logic        r_st, r_fn, r_g, r_rv;
        logic [2:0]  r_sel;
        logic [31:0] r_tgt;
        int          n;
        cycle(0, 0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 1, 1);
        #2;
        check("reset_addr", imem_addr_o, C_RESET_PC);
        check("reset_instr", instruction_o, C_NOP);

        // Back-to-back sequential fetches
        n = grants.size();
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 1, 0, 0);
            cycle(0, 0, 0, 0, 0, 1, 0);
            #2;
            check("seq_valid", {31'd0, valid_dec_o}, 32'd1);
        end
        check("seq_addr0", grants[n], 32'h0);
        check("seq_addr1", grants[n+1], 32'h4);
        check("seq_addr2", grants[n+2], 32'h8);

        // Response arriving mid-stall
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 1, 1, 0);
        cycle(1, 0, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        #2;
        check("stall_deliver", instruction_o, mem_word(32'hC));

        // Branch while waiting kills the late response
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 1, 32'h100, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        #2;
        check("kill_valid", {31'd0, valid_dec_o}, 32'd0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        check("redirect_addr", grants[grants.size()-1], 32'h100);
        cycle(0, 0, 0, 0, 0, 1, 0);

        // fetch_nop on the response edge
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 1, 0);
        #2;
        check("nop_instr", instruction_o, C_NOP);
        check("nop_valid", {31'd0, valid_dec_o}, 32'd0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        check("nop_next_addr", grants[grants.size()-1], 32'h108);

        // Reset with a request outstanding, plus stray responses
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 1, 0);
        #2;
        check("post_rst_valid", {31'd0, valid_dec_o}, 32'd0);
        check("post_rst_pc_dec", pc_dec_o, C_RESET_PC);
        cycle(0, 0, 0, 0, 1, 0, 0);
        check("post_rst_addr", grants[grants.size()-1], C_RESET_PC);
        cycle(0, 0, 0, 0, 0, 1, 0);

        // PC wrap at the top of the address space
        cycle(0, 3, 32'hFFFF_FFFC - 32'h80, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        check("wrap_addr", grants[grants.size()-1], 32'h0);
        cycle(0, 0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            r_st = ($urandom % 5) == 0;
            n = $urandom % 16;
            r_sel = (n < 3) ? 3'(n + 1) : (n == 3) ? 3'(4 + ($urandom % 4)) : 3'd0;
            r_tgt = {$urandom, 2'b00} >> 0;
            r_tgt[1:0] = 2'b00;
            r_fn = ($urandom % 8) == 0;
            r_g = ($urandom % 4) != 0;
            r_rv = m_out && (($urandom % 3) == 0);
            cycle(r_st, r_sel, r_tgt, r_fn, r_g, r_rv, 0);
        end

        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, m_out, 0);
        @(negedge clk);
        #2;
        check("scoreboard_empty", expq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
